// File: rtl/shift_ctrl_pkg.sv
// Shared definitions for the shift sequencing controller.
//   - ctrl codes driven to the universal shift register datapath
//   - controller state encoding
//   - serial direction codes (as captured from the dir input)
package shift_ctrl_pkg;

  localparam logic [1:0] CTRL_HOLD  = 2'b00;
  localparam logic [1:0] CTRL_RIGHT = 2'b01;
  localparam logic [1:0] CTRL_LEFT  = 2'b10;
  localparam logic [1:0] CTRL_LOAD  = 2'b11;

  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Producer / serial-link bundle of the shift sequencing controller.
//   master : producer side (drives start_valid, din, dir; observes the rest)
//   slave  : controller side
// Signals: start_valid/start_ready handshake, din[N-1:0], dir,
//          sout, sout_valid, busy, done, ctrl_o[1:0], q_o[N-1:0].
interface shift_seq_ctrl_if #(
  parameter int N = 8
);
  logic         start_valid;
  logic         start_ready;
  logic [N-1:0] din;
  logic         dir;
  logic         sout;
  logic         sout_valid;
  logic         busy;
  logic         done;
  logic [1:0]   ctrl_o;
  logic [N-1:0] q_o;

  modport master (
    output start_valid, din, dir,
    input  start_ready, sout, sout_valid, busy, done, ctrl_o, q_o
  );

  modport slave (
    input  start_valid, din, dir,
    output start_ready, sout, sout_valid, busy, done, ctrl_o, q_o
  );
endinterface

// File: rtl/shift_reg_core.sv
// N-bit universal shift register: hold / shift-right / shift-left / load.
// Ports:
//   i_clk, i_reset : clock, asynchronous active-high reset (clears q)
//   i_ctrl[1:0]    : operation code (see shift_ctrl_pkg)
//   i_d[N-1:0]     : parallel load value
//   i_sin          : bit entering the vacated end when shifting
//   o_q[N-1:0]     : register contents
module shift_reg_core
  import shift_ctrl_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic [1:0]   i_ctrl,
  input  logic [N-1:0] i_d,
  input  logic         i_sin,
  output logic [N-1:0] o_q
);

  logic [N-1:0] r_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_q <= '0;
    end else begin
      case (i_ctrl)
        CTRL_RIGHT: r_q <= {i_sin, r_q[N-1:1]};
        CTRL_LEFT:  r_q <= {r_q[N-2:0], i_sin};
        CTRL_LOAD:  r_q <= i_d;
        default:    r_q <= r_q;
      endcase
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/shift_seq_ctrl.sv
// Parallel-to-serial sequencing controller. Accepts a word on a
// valid/ready handshake, loads it into a universal shift register and
// shifts it out MSB-first (dir=0) or LSB-first (dir=1), then pulses done.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : shift_seq_ctrl_if.slave (handshake, din, dir, sout,
//           sout_valid, busy, done, ctrl_o, q_o)
// Optional build macro SHIFT_PARITY_EN: appends one even-parity bit
// (XOR of the captured word) after the data bits, ctrl held meanwhile.
module shift_seq_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int   N    = 8,
  parameter logic FILL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  shift_seq_ctrl_if.slave  bus
);

  localparam int             CW   = $clog2(N + 1);
  localparam logic [CW-1:0]  LAST = CW'(N - 1);

  state_t         r_state;
  logic [N-1:0]   r_word;
  logic           r_dir;
  logic [CW-1:0]  r_cnt;
  logic           r_ready;
  logic           r_busy;
  logic           r_done;
  logic           r_sout_valid;
  logic [1:0]     r_ctrl;
  logic [N-1:0]   w_q;
  logic           w_data_bit;
  logic           w_sout;
`ifdef SHIFT_PARITY_EN
  logic           r_par_phase;
`endif

  shift_reg_core #(.N(N)) u_core (
    .i_clk   (clk),
    .i_reset (reset),
    .i_ctrl  (r_ctrl),
    .i_d     (r_word),
    .i_sin   (FILL),
    .o_q     (w_q)
  );

  // All control outputs are registered: each is set on the edge that
  // enters the state it belongs to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_word       <= '0;
      r_dir        <= DIR_MSB_FIRST;
      r_cnt        <= '0;
      r_ready      <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_sout_valid <= 1'b0;
      r_ctrl       <= CTRL_HOLD;
`ifdef SHIFT_PARITY_EN
      r_par_phase  <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start_valid && r_ready) begin
            r_word  <= bus.din;
            r_dir   <= bus.dir;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_ctrl  <= CTRL_LOAD;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          r_cnt        <= '0;
          r_sout_valid <= 1'b1;
          r_ctrl       <= (r_dir == DIR_LSB_FIRST) ? CTRL_RIGHT : CTRL_LEFT;
          r_state      <= SHIFT;
        end
        SHIFT: begin
`ifdef SHIFT_PARITY_EN
          if (r_par_phase) begin
            r_par_phase  <= 1'b0;
            r_sout_valid <= 1'b0;
            r_done       <= 1'b1;
            r_state      <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST) begin
              // Freeze the datapath while the parity bit goes out.
              r_ctrl      <= CTRL_HOLD;
              r_par_phase <= 1'b1;
            end
          end
`else
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_ctrl       <= CTRL_HOLD;
            r_sout_valid <= 1'b0;
            r_done       <= 1'b1;
            r_state      <= DONE;
          end
`endif
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_data_bit = (r_dir == DIR_LSB_FIRST) ? w_q[0] : w_q[N-1];

`ifdef SHIFT_PARITY_EN
  assign w_sout = r_sout_valid & (r_par_phase ? (^r_word) : w_data_bit);
`else
  assign w_sout = r_sout_valid & w_data_bit;
`endif

  assign bus.start_ready = r_ready;
  assign bus.sout        = w_sout;
  assign bus.sout_valid  = r_sout_valid;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.ctrl_o      = r_ctrl;
  assign bus.q_o         = w_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl (N=8, FILL=0): directed frame table plus
// hand-written sequences for busy-ignore and mid-frame reset.
module tb_shift_seq_ctrl;
  import shift_ctrl_pkg::*;

  localparam int N = 8;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  shift_seq_ctrl_if #(.N(N)) bus ();

  shift_seq_ctrl #(.N(N), .FILL(1'b0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] din;
    logic       dir;
    logic [7:0] seq;   // seq[7] is the first bit on the wire
    logic       par;   // expected parity bit
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_frame(input logic [7:0] din, input logic dir,
                           input logic [7:0] seq, input logic par, input string tag);
    @(negedge clk);
    chk({tag, " ready before accept"}, 32'(bus.start_ready), 32'd1);
    bus.start_valid = 1'b1;
    bus.din         = din;
    bus.dir         = dir;
    @(negedge clk);
    // Changing din/dir after the accept must not disturb the frame.
    bus.start_valid = 1'b0;
    bus.din         = ~din;
    bus.dir         = ~dir;
    chk({tag, " load ctrl"}, 32'(bus.ctrl_o), 32'(CTRL_LOAD));
    chk({tag, " load busy"}, 32'(bus.busy), 32'd1);
    chk({tag, " load sout_valid"}, 32'(bus.sout_valid), 32'd0);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      chk($sformatf("%s bit%0d valid", tag, i), 32'(bus.sout_valid), 32'd1);
      chk($sformatf("%s bit%0d", tag, i), 32'(bus.sout), 32'(seq[7-i]));
      if (i == 0)
        chk({tag, " shift ctrl"}, 32'(bus.ctrl_o), dir ? 32'(CTRL_RIGHT) : 32'(CTRL_LEFT));
    end
`ifdef SHIFT_PARITY_EN
    @(negedge clk);
    chk({tag, " parity valid"}, 32'(bus.sout_valid), 32'd1);
    chk({tag, " parity bit"}, 32'(bus.sout), 32'(par));
    chk({tag, " parity ctrl"}, 32'(bus.ctrl_o), 32'(CTRL_HOLD));
`else
    if (par === 1'bx) chk({tag, " parity field"}, 32'(par), 32'd0);
`endif
    @(negedge clk);
    chk({tag, " done pulse"}, 32'(bus.done), 32'd1);
    chk({tag, " done sout_valid"}, 32'(bus.sout_valid), 32'd0);
    chk({tag, " done sout"}, 32'(bus.sout), 32'd0);
    chk({tag, " done ready"}, 32'(bus.start_ready), 32'd0);
    @(negedge clk);
    chk({tag, " done clears"}, 32'(bus.done), 32'd0);
    chk({tag, " ready again"}, 32'(bus.start_ready), 32'd1);
    chk({tag, " idle busy"}, 32'(bus.busy), 32'd0);
    chk({tag, " q drained"}, 32'(bus.q_o), 32'd0);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " start_ready"}, 32'(bus.start_ready), 32'd1);
    chk({tag, " sout"}, 32'(bus.sout), 32'd0);
    chk({tag, " sout_valid"}, 32'(bus.sout_valid), 32'd0);
    chk({tag, " busy"}, 32'(bus.busy), 32'd0);
    chk({tag, " done"}, 32'(bus.done), 32'd0);
    chk({tag, " ctrl_o"}, 32'(bus.ctrl_o), 32'(CTRL_HOLD));
    chk({tag, " q_o"}, 32'(bus.q_o), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw_done;
    n_checks = 0;
    n_fail   = 0;

    vecs[0] = '{din: 8'b10101101, dir: 1'b0, seq: 8'b10101101, par: 1'b1};
    vecs[1] = '{din: 8'hC3,       dir: 1'b1, seq: 8'b11000011, par: 1'b0};
    vecs[2] = '{din: 8'h01,       dir: 1'b0, seq: 8'b00000001, par: 1'b1};
    vecs[3] = '{din: 8'h80,       dir: 1'b1, seq: 8'b00000001, par: 1'b1};
    vecs[4] = '{din: 8'h96,       dir: 1'b1, seq: 8'b01101001, par: 1'b0};

    bus.start_valid = 1'b0;
    bus.din         = '0;
    bus.dir         = 1'b0;
    reset           = 1'b1;

    // Reset held for two cycles
    @(negedge clk);
    @(negedge clk);
    chk_idle_outputs("reset held");
    reset = 1'b0;
    @(negedge clk);
    chk_idle_outputs("after reset");

    // Table-driven frames
    for (int v = 0; v < 5; v++)
      run_frame(vecs[v].din, vecs[v].dir, vecs[v].seq, vecs[v].par,
                $sformatf("vec%0d", v));

    // Busy ignore: start_valid held with 8'hFF during a frame of 8'h01
    @(negedge clk);
    bus.start_valid = 1'b1;
    bus.din         = 8'h01;
    bus.dir         = 1'b0;
    @(negedge clk);
    bus.din = 8'hFF;
    chk("busy load ready low", 32'(bus.start_ready), 32'd0);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      chk($sformatf("busy first bit%0d", i), 32'(bus.sout), (i == N - 1) ? 32'd1 : 32'd0);
      chk($sformatf("busy first ready%0d", i), 32'(bus.start_ready), 32'd0);
    end
`ifdef SHIFT_PARITY_EN
    @(negedge clk);
    chk("busy first parity", 32'(bus.sout), 32'd1);
`endif
    @(negedge clk);
    chk("busy first done", 32'(bus.done), 32'd1);
    chk("busy done ready low", 32'(bus.start_ready), 32'd0);
    @(negedge clk);
    chk("busy idle ready", 32'(bus.start_ready), 32'd1);
    @(negedge clk);
    bus.start_valid = 1'b0;
    chk("busy second load", 32'(bus.ctrl_o), 32'(CTRL_LOAD));
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      chk($sformatf("busy second bit%0d", i), 32'(bus.sout), 32'd1);
      chk($sformatf("busy second valid%0d", i), 32'(bus.sout_valid), 32'd1);
    end
`ifdef SHIFT_PARITY_EN
    @(negedge clk);
    chk("busy second parity", 32'(bus.sout), 32'd0);
`endif
    @(negedge clk);
    chk("busy second done", 32'(bus.done), 32'd1);
    @(negedge clk);
    chk("busy second ready", 32'(bus.start_ready), 32'd1);

    // Mid-frame reset after the third bit of 8'hA5 (1,0,1,...)
    @(negedge clk);
    bus.start_valid = 1'b1;
    bus.din         = 8'hA5;
    bus.dir         = 1'b0;
    @(negedge clk);
    bus.start_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("abort bit%0d", i), 32'(bus.sout), (i == 1) ? 32'd0 : 32'd1);
    end
    reset = 1'b1;
    #1;
    chk_idle_outputs("abort immediate");
    @(negedge clk);
    reset    = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      saw_done = saw_done | bus.done | bus.sout_valid;
    end
    chk("abort no done or bits", 32'(saw_done), 32'd0);
    chk_idle_outputs("abort settled");
    run_frame(8'h0F, 1'b0, 8'b00001111, 1'b0, "post-abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
